// File: rtl/hja_dbg_input_ctrl_if.sv
// Single-step request handshake between the board-input front end (master)
// and the CPU clock controller (slave).
interface hja_dbg_input_ctrl_if;
  logic        step_valid;
  logic        step_ack;
  logic [15:0] step_count;
  logic        step_dropped;

  modport master (
    output step_valid,
    output step_count,
    output step_dropped,
    input  step_ack
  );

  modport slave (
    input  step_valid,
    input  step_count,
    input  step_dropped,
    output step_ack
  );
endinterface

// File: rtl/hja_dbg_input_ctrl.sv
// Board-input front end: sync + debounce of DIP switches and STEP, LED page select,
// STEP valid/ack request. Define HJA_DBG_AUTOREPEAT_EN to enable STEP auto-repeat.
module hja_dbg_input_ctrl #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned DB_SAMPLES   = 4,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          sw_raw,
  input  logic                 btn_step_raw,
  output logic [15:0]          sw_db,
  output logic [7:0]           led_sel,
  output logic                 sel_changed,
  hja_dbg_input_ctrl_if.master step
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned NB = 17;

  logic [PW-1:0] pre_q;
  logic          tick;
  logic [NB-1:0] sync1_q, sync2_q, db_q;
  logic [3:0]    db_cnt [NB];
  logic          step_db, step_db_q, press;
  logic          valid_q, dropped_q, req_any;
  logic [15:0]   cnt_q;

  assign tick = (pre_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_q <= '0;
    else     pre_q <= tick ? '0 : pre_q + PW'(1);
  end

  // Bit 16 carries STEP so it shares the switch debounce path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {btn_step_raw, sw_raw};
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q <= '0;
      for (int unsigned i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else if (tick) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == 4'(DB_SAMPLES - 1)) begin
          db_q[i]   <= sync2_q[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 4'd1;
        end
      end
    end
  end

  assign sw_db   = db_q[15:0];
  assign step_db = db_q[16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_sel     <= '0;
      sel_changed <= 1'b0;
      step_db_q   <= 1'b0;
    end else begin
      led_sel     <= db_q[15:8];
      sel_changed <= (db_q[15:8] != led_sel);
      step_db_q   <= step_db;
    end
  end

  assign press = step_db & ~step_db_q;

`ifdef HJA_DBG_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {B_IDLE, B_HELD, B_REPEAT} bstate_t;
  bstate_t       b_state, b_next;
  logic [RW-1:0] rep_cnt_q, rep_cnt_next;
  logic          rep_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_state   <= B_IDLE;
      rep_cnt_q <= '0;
    end else begin
      b_state   <= b_next;
      rep_cnt_q <= rep_cnt_next;
    end
  end

  always_comb begin
    b_next       = b_state;
    rep_cnt_next = rep_cnt_q;
    rep_req      = 1'b0;
    case (b_state)
      B_IDLE: begin
        rep_cnt_next = '0;
        if (press) b_next = B_HELD;
      end
      B_HELD, B_REPEAT: begin
        if (!step_db) begin
          b_next       = B_IDLE;
          rep_cnt_next = '0;
        end else if (tick) begin
          if ((b_state == B_HELD   && rep_cnt_q == RW'(REPEAT_DELAY - 1)) ||
              (b_state == B_REPEAT && rep_cnt_q == RW'(REPEAT_RATE - 1))) begin
            b_next       = B_REPEAT;
            rep_req      = 1'b1;
            rep_cnt_next = '0;
          end else begin
            rep_cnt_next = rep_cnt_q + RW'(1);
          end
        end
      end
      default: b_next = B_IDLE;
    endcase
  end

  assign req_any = press | rep_req;
`else
  typedef enum logic {B_IDLE, B_HELD} bstate_t;
  bstate_t b_state, b_next;
  logic    unused_repeat_cfg;

  assign unused_repeat_cfg = (REPEAT_DELAY != 0) ^ (REPEAT_RATE != 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) b_state <= B_IDLE;
    else     b_state <= b_next;
  end

  // B_HELD only waits for release, so a press yields exactly one request
  always_comb begin
    b_next = b_state;
    case (b_state)
      B_IDLE:  if (press)    b_next = B_HELD;
      B_HELD:  if (!step_db) b_next = B_IDLE;
      default: b_next = B_IDLE;
    endcase
  end

  assign req_any = press;
`endif

  // An ack completing on the same edge as a new request re-raises valid; only
  // real presses (not repeats) against a pending request count as dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
      cnt_q     <= '0;
    end else if (valid_q && step.step_ack) begin
      cnt_q   <= cnt_q + 16'd1;
      valid_q <= req_any;
    end else if (req_any) begin
      if (!valid_q)   valid_q   <= 1'b1;
      else if (press) dropped_q <= 1'b1;
    end
  end

  assign step.step_valid   = valid_q;
  assign step.step_dropped = dropped_q;
  assign step.step_count   = cnt_q;

endmodule
